// File: rtl/game_undo_history_pkg.sv
// Shared constants and types for the game-state undo history.
// STATE_W must match the width of the downstream 4-to-1 game-state mux.
package game_undo_history_pkg;

    localparam int unsigned STATE_W    = 134;
    localparam int unsigned HIST_DEPTH = 4;
    localparam int unsigned HIST_PTR_W = 2;
    localparam int unsigned CNT_W      = 3;

    typedef logic [STATE_W-1:0]    state_t;
    typedef logic [HIST_PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0]      cnt_t;
    typedef logic [HIST_DEPTH-1:0] slot_we_t;

    // One-hot write enable for the slot addressed by a history pointer.
    function automatic slot_we_t ptr_onehot(input ptr_t p);
        slot_we_t one;
        one = slot_we_t'(1);
        return one << p;
    endfunction

endpackage

// File: rtl/game_undo_history_if.sv
// Bundle between the move/level logic and the undo history.
//   master: move/level logic (drives init/push/undo, reads history outputs)
//   slave : game_undo_history
//   init_valid/init_state : load level start state, discard history
//   push/push_state       : commit a new post-move snapshot
//   undo                  : step back one snapshot
//   slot_0..slot_3, sel   : mux data inputs and mux select
//   count, undo_ok        : number of valid snapshots, count > 1
//   undo_ack, push_drop   : one-cycle status pulses
interface game_undo_history_if;
    import game_undo_history_pkg::*;

    logic   init_valid;
    state_t init_state;
    logic   push;
    state_t push_state;
    logic   undo;
    state_t slot_0;
    state_t slot_1;
    state_t slot_2;
    state_t slot_3;
    ptr_t   sel;
    cnt_t   count;
    logic   undo_ok;
    logic   undo_ack;
    logic   push_drop;

    modport master (
        output init_valid, init_state, push, push_state, undo,
        input  slot_0, slot_1, slot_2, slot_3, sel, count, undo_ok, undo_ack, push_drop
    );

    modport slave (
        input  init_valid, init_state, push, push_state, undo,
        output slot_0, slot_1, slot_2, slot_3, sel, count, undo_ok, undo_ack, push_drop
    );

endinterface

// File: rtl/game_undo_ctrl.sv
// Pointer/count control for the undo history.
// Resolves init > undo > push each cycle, keeps the current-snapshot pointer (sel)
// and the saturating valid count, and emits a one-hot slot write enable.
//   clk, rst_n            : clock, async active-low reset
//   init_valid, push, undo: requests (level-sampled)
//   sel, count            : registered pointer and valid count
//   undo_ok               : count > 1 (combinational)
//   undo_ack, push_drop   : registered one-cycle pulses
//   slot_we               : one-hot slot write enable for this cycle
//   wr_init               : write data comes from init_state instead of push_state
module game_undo_ctrl
    import game_undo_history_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     init_valid,
    input  logic     push,
    input  logic     undo,
    output ptr_t     sel,
    output cnt_t     count,
    output logic     undo_ok,
    output logic     undo_ack,
    output logic     push_drop,
    output slot_we_t slot_we,
    output logic     wr_init
);

    localparam cnt_t CntFull = cnt_t'(HIST_DEPTH);

    ptr_t sel_q, sel_d;
    cnt_t count_q, count_d;
    logic ack_q, ack_d;
    logic drop_q, drop_d;
    logic undo_accept;
    ptr_t wr_ptr;

    assign undo_accept = undo && (count_q > cnt_t'(1));
    assign wr_ptr      = sel_q + ptr_t'(1);

    always_comb begin
        sel_d   = sel_q;
        count_d = count_q;
        ack_d   = 1'b0;
        drop_d  = 1'b0;
        slot_we = '0;
        wr_init = 1'b0;
        if (init_valid) begin
            slot_we = ptr_onehot(ptr_t'(0));
            wr_init = 1'b1;
            sel_d   = '0;
            count_d = cnt_t'(1);
            drop_d  = push;
        end else if (undo_accept) begin
            // Undo is only a pointer move; slot contents stay for a later overwrite.
            sel_d   = sel_q - ptr_t'(1);
            count_d = count_q - cnt_t'(1);
            ack_d   = 1'b1;
            drop_d  = push;
        end else if (push) begin
            if (count_q == '0) begin
                // No level loaded yet: the first push acts as the start state.
                slot_we = ptr_onehot(ptr_t'(0));
                sel_d   = '0;
                count_d = cnt_t'(1);
            end else begin
                // Writing at sel+1 also discards any redo entries beyond sel.
                slot_we = ptr_onehot(wr_ptr);
                sel_d   = wr_ptr;
                count_d = (count_q == CntFull) ? count_q : count_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            count_q <= '0;
            ack_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            count_q <= count_d;
            ack_q   <= ack_d;
            drop_q  <= drop_d;
        end
    end

    assign sel       = sel_q;
    assign count     = count_q;
    assign undo_ok   = count_q > cnt_t'(1);
    assign undo_ack  = ack_q;
    assign push_drop = drop_q;

endmodule

// File: rtl/game_undo_history.sv
// Four-entry circular history of game-state snapshots feeding the 4-to-1 state mux.
// Undo moves the mux select back instead of copying data.
//   clk, rst_n : clock, async active-low reset
//   bus        : game_undo_history_if.slave (requests in; slots, sel, status out)
module game_undo_history
    import game_undo_history_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    game_undo_history_if.slave   bus
);

    slot_we_t slot_we;
    logic     wr_init;
    state_t   wr_data;
    state_t   slot_q [HIST_DEPTH];

    game_undo_ctrl u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_valid (bus.init_valid),
        .push       (bus.push),
        .undo       (bus.undo),
        .sel        (bus.sel),
        .count      (bus.count),
        .undo_ok    (bus.undo_ok),
        .undo_ack   (bus.undo_ack),
        .push_drop  (bus.push_drop),
        .slot_we    (slot_we),
        .wr_init    (wr_init)
    );

    assign wr_data = wr_init ? bus.init_state : bus.push_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                if (slot_we[i]) begin
                    slot_q[i] <= wr_data;
                end
            end
        end
    end

    assign bus.slot_0 = slot_q[0];
    assign bus.slot_1 = slot_q[1];
    assign bus.slot_2 = slot_q[2];
    assign bus.slot_3 = slot_q[3];

endmodule

// File: tb/tb_game_undo_history.sv
// Directed bench for game_undo_history with an expected-result queue.
module tb_game_undo_history;
    import game_undo_history_pkg::*;

    typedef struct {
        logic [1:0] sel;
        logic [2:0] cnt;
        logic       ok;
        logic       ack;
        logic       drop;
        state_t     s0;
        state_t     s1;
        state_t     s2;
        state_t     s3;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    exp_t       sb_q[$];
    logic [1:0] m_sel;
    logic [2:0] m_cnt;
    state_t     m_slot [4];

    game_undo_history_if bus ();

    game_undo_history dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic state_t mk(input int i);
        return {6'(i), 32'(i) * 32'h0101_0101, ~32'(i), 32'hdead_beef ^ 32'(i), 32'(i) << 4};
    endfunction

    task automatic chk(input string tag, input state_t got, input state_t exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_sel = '0;
        m_cnt = '0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        sb_q.delete();
    endtask

    task automatic sb_check();
        exp_t e;
        tests++;
        assert (sb_q.size() != 0) else begin
            fails++;
            $error("FAIL sb_empty observed=0 expected=1");
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sel",       state_t'(bus.sel),       state_t'(e.sel));
            chk("count",     state_t'(bus.count),     state_t'(e.cnt));
            chk("undo_ok",   state_t'(bus.undo_ok),   state_t'(e.ok));
            chk("undo_ack",  state_t'(bus.undo_ack),  state_t'(e.ack));
            chk("push_drop", state_t'(bus.push_drop), state_t'(e.drop));
            chk("slot_0",    bus.slot_0,              e.s0);
            chk("slot_1",    bus.slot_1,              e.s1);
            chk("slot_2",    bus.slot_2,              e.s2);
            chk("slot_3",    bus.slot_3,              e.s3);
        end
    endtask

    // Drive one cycle of requests, queue the expected result, clock, then compare.
    task automatic step(input logic iv, input state_t is, input logic p, input state_t ps,
                        input logic u);
        exp_t e;
        bus.init_valid = iv;
        bus.init_state = is;
        bus.push       = p;
        bus.push_state = ps;
        bus.undo       = u;
        e.ack  = 1'b0;
        e.drop = 1'b0;
        if (iv) begin
            m_slot[0] = is;
            m_sel     = 2'd0;
            m_cnt     = 3'd1;
            e.drop    = p;
        end else if (u && m_cnt > 3'd1) begin
            m_sel  = m_sel - 2'd1;
            m_cnt  = m_cnt - 3'd1;
            e.ack  = 1'b1;
            e.drop = p;
        end else if (p) begin
            if (m_cnt == 3'd0) begin
                m_slot[0] = ps;
                m_sel     = 2'd0;
                m_cnt     = 3'd1;
            end else begin
                m_sel         = m_sel + 2'd1;
                m_slot[m_sel] = ps;
                if (m_cnt < 3'd4) m_cnt = m_cnt + 3'd1;
            end
        end
        e.sel = m_sel;
        e.cnt = m_cnt;
        e.ok  = m_cnt > 3'd1;
        e.s0  = m_slot[0];
        e.s1  = m_slot[1];
        e.s2  = m_slot[2];
        e.s3  = m_slot[3];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        sb_check();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        state_t a, b, c, d, e5, f, x;
        state_t slot2_before;
        tests = 0;
        fails = 0;
        a  = mk(1);
        b  = mk(2);
        c  = mk(3);
        d  = mk(4);
        e5 = mk(5);
        f  = mk(6);
        x  = mk(9);
        rst_n          = 1'b0;
        bus.init_valid = 1'b0;
        bus.init_state = '0;
        bus.push       = 1'b0;
        bus.push_state = '0;
        bus.undo       = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Reset state, then undo with nothing stored is refused.
        idle();
        step(1'b0, '0, 1'b0, '0, 1'b1);

        // Push before any init acts as init.
        step(1'b0, '0, 1'b1, x, 1'b0);
        chk("push_as_init_slot0", bus.slot_0, x);

        // Reset then init.
        step(1'b1, a, 1'b0, '0, 1'b0);
        chk("init_slot0", bus.slot_0, a);
        chk("init_count", state_t'(bus.count), state_t'(3'd1));
        chk("init_undo_ok", state_t'(bus.undo_ok), state_t'(1'b0));

        // Push/undo walk.
        step(1'b0, '0, 1'b1, b, 1'b0);
        step(1'b0, '0, 1'b1, c, 1'b0);
        chk("walk_sel", state_t'(bus.sel), state_t'(2'd2));
        chk("walk_count", state_t'(bus.count), state_t'(3'd3));
        step(1'b0, '0, 1'b0, '0, 1'b1);
        chk("walk_ack", state_t'(bus.undo_ack), state_t'(1'b1));
        idle();
        step(1'b0, '0, 1'b0, '0, 1'b1);
        chk("walk_sel0", state_t'(bus.sel), state_t'(2'd0));
        step(1'b0, '0, 1'b0, '0, 1'b1);
        chk("walk_refused_ack", state_t'(bus.undo_ack), state_t'(1'b0));

        // Wrap: fifth snapshot overwrites slot 0.
        step(1'b1, a, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, b, 1'b0);
        step(1'b0, '0, 1'b1, c, 1'b0);
        step(1'b0, '0, 1'b1, d, 1'b0);
        step(1'b0, '0, 1'b1, e5, 1'b0);
        chk("wrap_slot0", bus.slot_0, e5);
        chk("wrap_count", state_t'(bus.count), state_t'(3'd4));
        repeat (3) step(1'b0, '0, 1'b0, '0, 1'b1);
        chk("wrap_sel", state_t'(bus.sel), state_t'(2'd1));
        chk("wrap_slot1", bus.slot_1, b);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        chk("wrap_refused_sel", state_t'(bus.sel), state_t'(2'd1));

        // Conflict: accepted undo drops the concurrent push.
        step(1'b1, a, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, b, 1'b0);
        slot2_before = bus.slot_2;
        step(1'b0, '0, 1'b1, f, 1'b1);
        chk("conflict_drop", state_t'(bus.push_drop), state_t'(1'b1));
        chk("conflict_slot2", bus.slot_2, slot2_before);
        idle();

        // Refused undo lets the push through.
        step(1'b0, '0, 1'b1, c, 1'b1);

        // Init overrides undo and push.
        step(1'b1, a, 1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1, b, 1'b0);
        step(1'b0, '0, 1'b1, c, 1'b0);
        step(1'b1, f, 1'b1, d, 1'b1);
        chk("init_ovr_slot0", bus.slot_0, f);
        chk("init_ovr_drop", state_t'(bus.push_drop), state_t'(1'b1));

        // Push after undo discards redo; held push saturates count.
        step(1'b0, '0, 1'b1, b, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1, d, 1'b0);
        repeat (5) step(1'b0, '0, 1'b1, e5, 1'b0);
        chk("held_push_count", state_t'(bus.count), state_t'(3'd4));

        // Async reset mid-push.
        bus.push       = 1'b1;
        bus.push_state = x;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", state_t'(bus.sel), '0);
        chk("arst_count", state_t'(bus.count), '0);
        chk("arst_slot0", bus.slot_0, '0);
        chk("arst_slot3", bus.slot_3, '0);
        @(posedge clk);
        #1;
        chk("arst_no_write", bus.slot_1 | bus.slot_2 | bus.slot_0 | bus.slot_3, '0);
        bus.push = 1'b0;
        #2;
        rst_n = 1'b1;
        model_clear();
        idle();
        step(1'b0, '0, 1'b1, c, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Bound total runtime in case stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
